fir_filter_cfg: RTL and testbench

//  Parametrised, valid-qualified FIR filter with runtime-writable coefficient banks.

---
 rtl/fir_filter_cfg_if.sv | 32 +++
 rtl/fir_filter_cfg.sv | 155 +++++++++++++++
 tb/tb_fir_filter_cfg.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_filter_cfg_if.sv
// rtl/fir_filter_cfg_if.sv - sample stream and coefficient write bus of the configurable FIR
interface fir_filter_cfg_if #(
   parameter int NUM_COEFF = 17,
   parameter int NUM_BANKS = 4,
   parameter int NBT_IN    = 8,
   parameter int NBT_COEFF = 8,
   parameter int NBT_OUT   = 8
);
   localparam int NB_SEL  = $clog2(NUM_BANKS);
   localparam int NB_ADDR = $clog2(NUM_COEFF);

   logic                        i_valid;
   logic signed [NBT_IN-1:0]    i_is_data;
   logic [NB_SEL-1:0]           i_sel_bank;
   logic                        i_coeff_we;
   logic [NB_SEL-1:0]           i_coeff_bank;
   logic [NB_ADDR-1:0]          i_coeff_addr;
   logic signed [NBT_COEFF-1:0] i_coeff_data;
   logic                        o_valid;
   logic signed [NBT_OUT-1:0]   o_os_data;
   logic                        o_sat;

   modport master (
      output i_valid, i_is_data, i_sel_bank, i_coeff_we, i_coeff_bank, i_coeff_addr, i_coeff_data,
      input  o_valid, o_os_data, o_sat
   );

   modport slave (
      input  i_valid, i_is_data, i_sel_bank, i_coeff_we, i_coeff_bank, i_coeff_addr, i_coeff_data,
      output o_valid, o_os_data, o_sat
   );
endinterface

// File: rtl/fir_filter_cfg.sv
// rtl/fir_filter_cfg.sv - valid-qualified FIR with writable coefficient banks
// Pipelined adder tree, round-half-up and saturation to S(NBT_OUT,NBF_OUT).
module fir_filter_cfg #(
   parameter int NUM_COEFF = 17,
   parameter int NUM_BANKS = 4,
   parameter int NBT_IN    = 8,
   parameter int NBF_IN    = 7,
   parameter int NBT_COEFF = 8,
   parameter int NBF_COEFF = 7,
   parameter int NBT_OUT   = 8,
   parameter int NBF_OUT   = 7
) (
   input  logic            clk,
   input  logic            i_reset,
   fir_filter_cfg_if.slave bus
);
   localparam int NB_SEL     = $clog2(NUM_BANKS);
   localparam int NUM_LEVELS = $clog2(NUM_COEFF);
   localparam int NBT_PROD   = NBT_IN + NBT_COEFF;
   localparam int NBT_ADD    = NBT_PROD + NUM_LEVELS;
   localparam int NBF_ADD    = NBF_IN + NBF_COEFF;
   localparam int NB_DROP    = NBF_ADD - NBF_OUT;
   localparam int NBT_RND    = NBT_ADD + 1 - NB_DROP;

   logic signed [NBT_COEFF-1:0] bank_mem [NUM_BANKS][NUM_COEFF];
   logic [NB_SEL-1:0]           sel_q;
   logic signed [NBT_COEFF-1:0] coeff_ws [NUM_COEFF];

   logic                        in_vld_q;
   logic signed [NBT_IN-1:0]    in_data_q;
   logic                        sr_vld_q;
   logic signed [NBT_IN-1:0]    taps_q [NUM_COEFF];
   logic                        prod_vld_q;
   logic signed [NBT_PROD-1:0]  prod_q [NUM_COEFF];
   logic signed [NBT_ADD-1:0]   prod_ext [NUM_COEFF];
   logic signed [NBT_ADD-1:0]   tree_q [1:NUM_LEVELS][NUM_COEFF];
   logic [NUM_LEVELS-1:0]       tree_vld_q;

   logic [NBT_RND-1:0]          rnd;
   logic                        ovf;
   logic [NBT_OUT-1:0]          sat_data;

   function automatic int level_count(input int lv);
      int n;
      n = NUM_COEFF;
      for (int k = 0; k < lv; k++) n = (n + 1) / 2;
      return n;
   endfunction

   // Selection is registered too, so bank switches and writes share the same two-edge delay.
   always_ff @(posedge clk) begin
      if (i_reset) begin
         sel_q <= '0;
         for (int b = 0; b < NUM_BANKS; b++)
            for (int k = 0; k < NUM_COEFF; k++) bank_mem[b][k] <= '0;
         for (int k = 0; k < NUM_COEFF; k++) coeff_ws[k] <= '0;
      end else begin
         sel_q <= bus.i_sel_bank;
         if (bus.i_coeff_we && (int'(bus.i_coeff_addr) < NUM_COEFF))
            bank_mem[bus.i_coeff_bank][bus.i_coeff_addr] <= bus.i_coeff_data;
         for (int k = 0; k < NUM_COEFF; k++) coeff_ws[k] <= bank_mem[sel_q][k];
      end
   end

   always_ff @(posedge clk) begin
      if (i_reset) begin
         in_vld_q   <= 1'b0;
         in_data_q  <= '0;
         sr_vld_q   <= 1'b0;
         prod_vld_q <= 1'b0;
         for (int k = 0; k < NUM_COEFF; k++) begin
            taps_q[k] <= '0;
            prod_q[k] <= '0;
         end
      end else begin
         in_vld_q  <= bus.i_valid;
         in_data_q <= bus.i_is_data;
         sr_vld_q  <= in_vld_q;
         if (in_vld_q) begin
            taps_q[0] <= in_data_q;
            for (int k = 1; k < NUM_COEFF; k++) taps_q[k] <= taps_q[k-1];
         end
         prod_vld_q <= sr_vld_q;
         for (int k = 0; k < NUM_COEFF; k++)
            prod_q[k] <= NBT_PROD'(taps_q[k]) * NBT_PROD'(coeff_ws[k]);
      end
   end

   always_comb begin
      for (int k = 0; k < NUM_COEFF; k++) prod_ext[k] = NBT_ADD'(prod_q[k]);
   end

   // The modulo only keeps indices in range; it never changes an operand that is actually summed.
   always_ff @(posedge clk) begin
      if (i_reset) begin
         tree_vld_q <= '0;
         for (int lv = 1; lv <= NUM_LEVELS; lv++)
            for (int i = 0; i < NUM_COEFF; i++) tree_q[lv][i] <= '0;
      end else begin
         tree_vld_q[0] <= prod_vld_q;
         for (int lv = 1; lv < NUM_LEVELS; lv++) tree_vld_q[lv] <= tree_vld_q[lv-1];
         for (int i = 0; i < NUM_COEFF; i++) begin
            if (2*i + 1 < NUM_COEFF)
               tree_q[1][i] <= prod_ext[(2*i) % NUM_COEFF] + prod_ext[(2*i+1) % NUM_COEFF];
            else if (2*i < NUM_COEFF)
               tree_q[1][i] <= prod_ext[(2*i) % NUM_COEFF];
            else
               tree_q[1][i] <= '0;
         end
         for (int lv = 2; lv <= NUM_LEVELS; lv++) begin
            for (int i = 0; i < NUM_COEFF; i++) begin
               if (2*i + 1 < level_count(lv-1))
                  tree_q[lv][i] <= tree_q[lv-1][(2*i) % NUM_COEFF] + tree_q[lv-1][(2*i+1) % NUM_COEFF];
               else if (2*i < level_count(lv-1))
                  tree_q[lv][i] <= tree_q[lv-1][(2*i) % NUM_COEFF];
               else
                  tree_q[lv][i] <= '0;
            end
         end
      end
   end

   // Adding half an LSB then truncating equals the truncated value plus the first dropped bit.
   generate
      if (NB_DROP > 0) begin : g_round
         always_comb begin
            rnd = NBT_RND'({tree_q[NUM_LEVELS][0][NBT_ADD-1], tree_q[NUM_LEVELS][0][NBT_ADD-1:NB_DROP]})
                + NBT_RND'(tree_q[NUM_LEVELS][0][NB_DROP-1]);
         end
      end else begin : g_no_round
         always_comb begin
            rnd = {tree_q[NUM_LEVELS][0][NBT_ADD-1], tree_q[NUM_LEVELS][0]};
         end
      end
   endgenerate

   always_comb begin
      ovf      = !((&rnd[NBT_RND-1:NBT_OUT-1]) || !(|rnd[NBT_RND-1:NBT_OUT-1]));
      sat_data = ovf ? {rnd[NBT_RND-1], {(NBT_OUT-1){~rnd[NBT_RND-1]}}} : rnd[NBT_OUT-1:0];
   end

   always_ff @(posedge clk) begin
      if (i_reset) begin
         bus.o_valid   <= 1'b0;
         bus.o_os_data <= '0;
         bus.o_sat     <= 1'b0;
      end else begin
         bus.o_valid <= tree_vld_q[NUM_LEVELS-1];
         if (tree_vld_q[NUM_LEVELS-1]) begin
            bus.o_os_data <= sat_data;
            bus.o_sat     <= ovf;
         end
      end
   end
endmodule

// File: tb/tb_fir_filter_cfg.sv
// tb/tb_fir_filter_cfg.sv - directed self-checking bench for fir_filter_cfg
module tb_fir_filter_cfg;
   localparam int NUM_COEFF = 17;
   localparam int LAT       = 8;

   logic clk = 1'b0;
   logic i_reset;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   logic [7:0] out_data_q[$];
   logic       out_sat_q[$];
   int         out_cyc_q[$];

   fir_filter_cfg_if bus ();

   fir_filter_cfg dut (
      .clk     (clk),
      .i_reset (i_reset),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.o_valid === 1'b1) begin
         out_data_q.push_back(bus.o_os_data);
         out_sat_q.push_back(bus.o_sat);
         out_cyc_q.push_back(cyc);
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_outputs();
      out_data_q.delete();
      out_sat_q.delete();
      out_cyc_q.delete();
   endtask

   task automatic idle_inputs();
      bus.i_valid      = 1'b0;
      bus.i_is_data    = '0;
      bus.i_sel_bank   = '0;
      bus.i_coeff_we   = 1'b0;
      bus.i_coeff_bank = '0;
      bus.i_coeff_addr = '0;
      bus.i_coeff_data = '0;
   endtask

   task automatic do_reset();
      i_reset = 1'b1;
      tick(2);
      i_reset = 1'b0;
      tick(1);
      clear_outputs();
   endtask

   task automatic write_coeff(input int b, input int a, input logic [7:0] d);
      bus.i_coeff_we   = 1'b1;
      bus.i_coeff_bank = 2'(b);
      bus.i_coeff_addr = 5'(a);
      bus.i_coeff_data = d;
      tick(1);
      bus.i_coeff_we   = 1'b0;
   endtask

   task automatic send(input logic [7:0] x, output int e);
      bus.i_valid   = 1'b1;
      bus.i_is_data = x;
      e             = cyc + 1;
      tick(1);
      bus.i_valid   = 1'b0;
   endtask

   task automatic test_reset();
      int e;
      i_reset          = 1'b1;
      bus.i_valid      = 1'b1;
      bus.i_is_data    = 8'h7F;
      bus.i_coeff_we   = 1'b1;
      bus.i_coeff_data = 8'h7F;
      tick(3);
      i_reset = 1'b0;
      idle_inputs();
      tick(1);
      total++;
      if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL reset_o_valid got=%b want=0", bus.o_valid); end
      total++;
      if (bus.o_os_data !== 8'h00) begin bad++; $display("FAIL reset_o_os_data got=%h want=00", bus.o_os_data); end
      total++;
      if (bus.o_sat !== 1'b0) begin bad++; $display("FAIL reset_o_sat got=%b want=0", bus.o_sat); end
      clear_outputs();
      send(8'h7F, e);
      tick(LAT + 4);
      total++;
      if (out_data_q.size() !== 1) begin bad++; $display("FAIL reset_out_count got=%0d want=1", out_data_q.size()); end
      if (out_data_q.size() > 0) begin
         total++;
         if (out_data_q[0] !== 8'h00) begin bad++; $display("FAIL reset_bank_zero got=%h want=00", out_data_q[0]); end
         total++;
         if (out_cyc_q[0] !== e + LAT) begin bad++; $display("FAIL reset_latency got=%0d want=%0d", out_cyc_q[0], e + LAT); end
      end
   endtask

   task automatic test_impulse();
      int e, d;
      do_reset();
      write_coeff(0, 0, 8'h10);
      send(8'h40, e);
      for (int i = 1; i < NUM_COEFF; i++) send(8'h00, d);
      tick(LAT + 4);
      total++;
      if (out_data_q.size() !== NUM_COEFF) begin bad++; $display("FAIL impulse_count got=%0d want=%0d", out_data_q.size(), NUM_COEFF); end
      for (int i = 0; i < out_data_q.size(); i++) begin
         total++;
         if (out_data_q[i] !== ((i == 0) ? 8'h08 : 8'h00) || out_sat_q[i] !== 1'b0 || out_cyc_q[i] !== e + LAT + i) begin
            bad++;
            $display("FAIL impulse_out[%0d] got=%h sat=%b cyc=%0d want=%h sat=0 cyc=%0d", i, out_data_q[i], out_sat_q[i],
                     out_cyc_q[i], (i == 0) ? 8'h08 : 8'h00, e + LAT + i);
         end
      end
   endtask

   task automatic test_tap_walk();
      int e, d;
      do_reset();
      for (int k = 0; k < NUM_COEFF; k++) write_coeff(0, k, 8'(k + 1));
      send(8'h7F, e);
      for (int i = 1; i < NUM_COEFF; i++) send(8'h00, d);
      tick(LAT + 4);
      total++;
      if (out_data_q.size() !== NUM_COEFF) begin bad++; $display("FAIL tapwalk_count got=%0d want=%0d", out_data_q.size(), NUM_COEFF); end
      for (int i = 0; i < out_data_q.size(); i++) begin
         total++;
         if (out_data_q[i] !== 8'(i + 1) || out_sat_q[i] !== 1'b0) begin
            bad++;
            $display("FAIL tapwalk_out[%0d] got=%h sat=%b want=%h sat=0", i, out_data_q[i], out_sat_q[i], 8'(i + 1));
         end
      end
   endtask

   task automatic test_saturation();
      int d;
      do_reset();
      for (int k = 0; k < NUM_COEFF; k++) write_coeff(0, k, 8'h7F);
      for (int i = 0; i < 20; i++) send(8'h7F, d);
      for (int i = 0; i < 20; i++) send(8'h80, d);
      tick(LAT + 4);
      total++;
      if (out_data_q.size() !== 40) begin bad++; $display("FAIL sat_count got=%0d want=40", out_data_q.size()); end
      if (out_data_q.size() == 40) begin
         total++;
         if (out_data_q[0] !== 8'h7E || out_sat_q[0] !== 1'b0) begin
            bad++; $display("FAIL sat_first got=%h sat=%b want=7e sat=0", out_data_q[0], out_sat_q[0]);
         end
         total++;
         if (out_data_q[1] !== 8'h7F || out_sat_q[1] !== 1'b1) begin
            bad++; $display("FAIL sat_second got=%h sat=%b want=7f sat=1", out_data_q[1], out_sat_q[1]);
         end
         for (int i = 16; i < 20; i++) begin
            total++;
            if (out_data_q[i] !== 8'h7F || out_sat_q[i] !== 1'b1) begin
               bad++; $display("FAIL sat_pos[%0d] got=%h sat=%b want=7f sat=1", i, out_data_q[i], out_sat_q[i]);
            end
         end
         for (int i = 36; i < 40; i++) begin
            total++;
            if (out_data_q[i] !== 8'h80 || out_sat_q[i] !== 1'b1) begin
               bad++; $display("FAIL sat_neg[%0d] got=%h sat=%b want=80 sat=1", i, out_data_q[i], out_sat_q[i]);
            end
         end
      end
   endtask

   task automatic test_rounding();
      logic [7:0] xin [5];
      logic [7:0] exp [5];
      int d;
      xin = '{8'h40, 8'hC0, 8'h20, 8'hBF, 8'h41};
      exp = '{8'h01, 8'h00, 8'h00, 8'hFF, 8'h01};
      do_reset();
      write_coeff(0, 0, 8'h01);
      for (int i = 0; i < 5; i++) send(xin[i], d);
      tick(LAT + 4);
      total++;
      if (out_data_q.size() !== 5) begin bad++; $display("FAIL round_count got=%0d want=5", out_data_q.size()); end
      for (int i = 0; i < out_data_q.size() && i < 5; i++) begin
         total++;
         if (out_data_q[i] !== exp[i] || out_sat_q[i] !== 1'b0) begin
            bad++; $display("FAIL round_in_%h got=%h sat=%b want=%h sat=0", xin[i], out_data_q[i], out_sat_q[i], exp[i]);
         end
      end
   endtask

   task automatic test_bank_switch();
      int s_edge, w_edge, c;
      logic [7:0] exp;
      do_reset();
      write_coeff(0, 0, 8'h40);
      write_coeff(1, 0, 8'h20);
      bus.i_sel_bank = 2'd0;
      s_edge = 0;
      w_edge = 0;
      for (int i = 0; i < 40; i++) begin
         bus.i_valid   = 1'b1;
         bus.i_is_data = 8'h40;
         if (i == 10) begin
            bus.i_sel_bank = 2'd1;
            s_edge = cyc + 1;
         end
         if (i == 22) begin
            bus.i_coeff_we   = 1'b1;
            bus.i_coeff_bank = 2'd1;
            bus.i_coeff_addr = 5'd0;
            bus.i_coeff_data = 8'h7F;
            w_edge = cyc + 1;
         end else begin
            bus.i_coeff_we = 1'b0;
         end
         tick(1);
      end
      bus.i_valid = 1'b0;
      tick(LAT + 4);
      total++;
      if (out_data_q.size() !== 40) begin bad++; $display("FAIL bank_count got=%0d want=40", out_data_q.size()); end
      for (int i = 0; i < out_data_q.size(); i++) begin
         c   = out_cyc_q[i];
         exp = (c >= w_edge + LAT) ? 8'h40 : (c >= s_edge + LAT) ? 8'h10 : 8'h20;
         total++;
         if (out_data_q[i] !== exp) begin
            bad++; $display("FAIL bank_out[%0d] cyc=%0d got=%h want=%h", i, c, out_data_q[i], exp);
         end
      end
      bus.i_sel_bank = 2'd0;
   endtask

   task automatic test_gaps_reset();
      int coef [NUM_COEFF];
      int xs[$];
      int sum, r, e, d;
      logic signed [7:0] xv;
      logic [7:0] exp;
      logic exp_sat;
      coef = '{3, -5, 8, -12, 20, -30, 40, -20, 64, -20, 40, -30, 20, -12, 8, -5, 3};
      do_reset();
      for (int k = 0; k < NUM_COEFF; k++) write_coeff(0, k, 8'(coef[k]));
      for (int n = 0; n < 24; n++) begin
         xv = 8'($urandom_range(0, 255));
         xs.push_back(int'(xv));
         send(xv, d);
         tick(2);
      end
      tick(LAT + 4);
      total++;
      if (out_data_q.size() !== 24) begin bad++; $display("FAIL gaps_count got=%0d want=24", out_data_q.size()); end
      for (int n = 0; n < out_data_q.size() && n < 24; n++) begin
         sum = 0;
         for (int k = 0; k < NUM_COEFF; k++)
            if (n - k >= 0) sum += xs[n-k] * coef[k];
         r       = (sum + 64) >>> 7;
         exp_sat = (r > 127) || (r < -128);
         exp     = (r > 127) ? 8'h7F : (r < -128) ? 8'h80 : 8'(r);
         total++;
         if (out_data_q[n] !== exp || out_sat_q[n] !== exp_sat) begin
            bad++; $display("FAIL gaps_out[%0d] got=%h sat=%b want=%h sat=%b", n, out_data_q[n], out_sat_q[n], exp, exp_sat);
         end
      end
      clear_outputs();
      for (int i = 0; i < 3; i++) send(8'h7F, d);
      tick(2);
      i_reset = 1'b1;
      tick(1);
      i_reset = 1'b0;
      tick(LAT + 4);
      total++;
      if (out_data_q.size() !== 0) begin bad++; $display("FAIL midreset_stale got=%0d want=0", out_data_q.size()); end
      clear_outputs();
      write_coeff(0, 0, 8'h40);
      write_coeff(0, 1, 8'h40);
      send(8'h40, e);
      tick(LAT + 4);
      total++;
      if (out_data_q.size() !== 1) begin bad++; $display("FAIL midreset_count got=%0d want=1", out_data_q.size()); end
      if (out_data_q.size() > 0) begin
         total++;
         if (out_data_q[0] !== 8'h20 || out_cyc_q[0] !== e + LAT) begin
            bad++; $display("FAIL midreset_out got=%h cyc=%0d want=20 cyc=%0d", out_data_q[0], out_cyc_q[0], e + LAT);
         end
      end
   endtask

   initial begin
      i_reset = 1'b1;
      idle_inputs();
      test_reset();
      test_impulse();
      test_tap_walk();
      test_saturation();
      test_rounding();
      test_bank_switch();
      test_gaps_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
